// File: rtl/fsm_stream_sched_if.sv
// Host-side bundle for fsm_stream_sched: start/abort/din request plus status and results.
interface fsm_stream_sched_if #(
   parameter int WIDTH = 8
);
   localparam int CW = $clog2(WIDTH + 1);

   logic                 start;
   logic                 abort;
   logic [WIDTH-1:0]     din;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   y_log;
   logic [CW-1:0]        match_cnt;
   logic [1:0]           last_y;

   modport master (
      output start, abort, din,
      input  busy, done, y_log, match_cnt, last_y
   );

   modport slave (
      input  start, abort, din,
      output busy, done, y_log, match_cnt, last_y
   );
endinterface

// File: rtl/fsm_stream_sched.sv
// Streams a captured word LSB-first into a Mealy detector after resetting it,
// logging every 2-bit response and counting those equal to CODE.
//
// state | meaning
// IDLE  | waiting for start; results from the last run hold
// INIT  | one cycle holding the detector in reset
// RUN   | WIDTH cycles, one serial bit per cycle, response logged each edge
// DONE  | one-cycle done pulse, then back to IDLE
module fsm_stream_sched #(
   parameter int         WIDTH = 8,
   parameter logic [1:0] CODE  = 2'b11
) (
   input  logic                 clk,
   input  logic                 reset,
   fsm_stream_sched_if.slave    host,
   output logic                 fsm_x,
   output logic                 fsm_rst,
   input  logic [1:0]           fsm_y
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     shreg_q, shreg_d;
   logic [CW-1:0]        idx_q, idx_d;
   logic [2*WIDTH-1:0]   y_log_q, y_log_d;
   logic [CW-1:0]        match_q, match_d;
   logic [1:0]           last_y_q, last_y_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         shreg_q  <= '0;
         idx_q    <= '0;
         y_log_q  <= '0;
         match_q  <= '0;
         last_y_q <= '0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         idx_q    <= idx_d;
         y_log_q  <= y_log_d;
         match_q  <= match_d;
         last_y_q <= last_y_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      idx_d    = idx_q;
      y_log_d  = y_log_q;
      match_d  = match_q;
      last_y_d = last_y_q;
      unique case (state_q)
         IDLE: begin
            if (host.start) begin
               state_d  = INIT;
               shreg_d  = host.din;
               idx_d    = '0;
               y_log_d  = '0;
               match_d  = '0;
               last_y_d = '0;
            end
         end
         INIT: begin
            state_d = host.abort ? IDLE : RUN;
         end
         RUN: begin
            // The step on an aborting edge is still recorded.
            for (int k = 0; k < WIDTH; k++) begin
               if (idx_q == CW'(k)) begin
                  y_log_d[2*k +: 2] = fsm_y;
               end
            end
            last_y_d = fsm_y;
            if (fsm_y == CODE) begin
               match_d = match_q + CW'(1);
            end
            shreg_d = shreg_q >> 1;
            idx_d   = idx_q + CW'(1);
            if (host.abort) begin
               state_d = IDLE;
            end else if (idx_q == CW'(WIDTH - 1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign host.busy      = (state_q == INIT) || (state_q == RUN);
   assign host.done      = (state_q == DONE);
   assign host.y_log     = y_log_q;
   assign host.match_cnt = match_q;
   assign host.last_y    = last_y_q;

   assign fsm_x   = (state_q == RUN) && shreg_q[0];
   assign fsm_rst = reset || (state_q == INIT);
endmodule

// File: tb/tb_fsm_stream_sched.sv
// Bench for fsm_stream_sched: two instances (CODE=11 and CODE=10) each driving a
// reference Mealy detector, checked every cycle against a run-level model.
module tb_fsm_stream_sched;
   localparam int W  = 8;
   localparam int CW = $clog2(W + 1);

   logic         clk;
   logic         reset;
   logic         start;
   logic         abort;
   logic [W-1:0] din;

   logic       fsm_x1, fsm_rst1, fsm_x2, fsm_rst2;
   logic [1:0] fsm_y1, fsm_y2;
   logic [1:0] det1_q, det2_q;
   logic [3:0] d1, d2;

   integer checks = 0;
   integer errors = 0;
   bit     chk_en = 0;

   fsm_stream_sched_if #(.WIDTH(W)) bus1 ();
   fsm_stream_sched_if #(.WIDTH(W)) bus2 ();

   assign bus1.start = start;
   assign bus1.abort = abort;
   assign bus1.din   = din;
   assign bus2.start = start;
   assign bus2.abort = abort;
   assign bus2.din   = din;

   fsm_stream_sched #(.WIDTH(W), .CODE(2'b11)) u_dut (
      .clk     (clk),
      .reset   (reset),
      .host    (bus1.slave),
      .fsm_x   (fsm_x1),
      .fsm_rst (fsm_rst1),
      .fsm_y   (fsm_y1)
   );

   fsm_stream_sched #(.WIDTH(W), .CODE(2'b10)) u_dut2 (
      .clk     (clk),
      .reset   (reset),
      .host    (bus2.slave),
      .fsm_x   (fsm_x2),
      .fsm_rst (fsm_rst2),
      .fsm_y   (fsm_y2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Detector: returns {next_state, y}
   function automatic logic [3:0] det_step(input logic [1:0] s, input logic x);
      case ({s, x})
         3'b000:  det_step = {2'b01, 2'b10};
         3'b001:  det_step = {2'b00, 2'b11};
         3'b010:  det_step = {2'b01, 2'b10};
         3'b011:  det_step = {2'b10, 2'b10};
         3'b100:  det_step = {2'b01, 2'b10};
         3'b101:  det_step = {2'b11, 2'b01};
         3'b110:  det_step = {2'b01, 2'b11};
         default: det_step = {2'b00, 2'b11};
      endcase
   endfunction

   assign d1     = det_step(det1_q, fsm_x1);
   assign d2     = det_step(det2_q, fsm_x2);
   assign fsm_y1 = d1[1:0];
   assign fsm_y2 = d2[1:0];

   always @(posedge clk) begin
      if (fsm_rst1) det1_q <= 2'b00; else det1_q <= d1[3:2];
      if (fsm_rst2) det2_q <= 2'b00; else det2_q <= d2[3:2];
   end

   // Run-level model: phase -1 idle, 0 init, 1..W serial step phase-1, W+1 done
   int              m_phase = -1;
   int              m_steps = 0;
   logic [W-1:0]    m_din   = '0;
   logic [2*W-1:0]  m_yfull = '0;

   always @(posedge clk) begin
      if (reset) begin
         m_phase = -1;
         m_steps = 0;
      end else if (m_phase == -1) begin
         if (start) begin
            logic [1:0] s;
            logic [3:0] r;
            m_phase = 0;
            m_steps = 0;
            m_din   = din;
            s = 2'b00;
            for (int k = 0; k < W; k++) begin
               r = det_step(s, din[k]);
               m_yfull[2*k +: 2] = r[1:0];
               s = r[3:2];
            end
         end
      end else if (m_phase == 0) begin
         m_phase = abort ? -1 : 1;
      end else if (m_phase <= W) begin
         m_steps = m_phase;
         m_phase = abort ? -1 : m_phase + 1;
      end else begin
         m_phase = -1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         logic [2*W-1:0] e_y;
         logic [1:0]     e_last, yy;
         int             e_m, e_m2;
         logic           e_x;
         e_y = '0; e_last = 2'b00; e_m = 0; e_m2 = 0;
         for (int k = 0; k < m_steps; k++) begin
            yy = m_yfull[2*k +: 2];
            e_y[2*k +: 2] = yy;
            if (yy == 2'b11) e_m++;
            if (yy == 2'b10) e_m2++;
            e_last = yy;
         end
         e_x = (m_phase >= 1 && m_phase <= W) ? m_din[m_phase-1] : 1'b0;
         chk("busy",      32'(bus1.busy),      32'(m_phase >= 0 && m_phase <= W));
         chk("done",      32'(bus1.done),      32'(m_phase == W + 1));
         chk("fsm_x",     32'(fsm_x1),         32'(e_x));
         chk("fsm_rst",   32'(fsm_rst1),       32'(reset || m_phase == 0));
         chk("y_log",     32'(bus1.y_log),     32'(e_y));
         chk("match_cnt", 32'(bus1.match_cnt), 32'(e_m));
         chk("last_y",    32'(bus1.last_y),    32'(e_last));
         chk("y_log2",    32'(bus2.y_log),     32'(e_y));
         chk("match_cnt2",32'(bus2.match_cnt), 32'(e_m2));
         chk("done2",     32'(bus2.done),      32'(m_phase == W + 1));
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic launch(input logic [W-1:0] d);
      din   = d;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // From the INIT cycle, tick until done or budget expires; n counts ticks.
   task automatic wait_done(input int budget, output int n);
      n = 0;
      while (!bus1.done && n < budget) begin
         tick();
         n++;
      end
      chk("done_reached", 32'(bus1.done), 32'd1);
   endtask

   int n;
   int dones;

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; din = '0;
      tick();
      chk_en = 1'b1;
      tick();
      chk("rst_fsm_rst", 32'(fsm_rst1), 32'd1);
      chk("rst_y_log",   32'(bus1.y_log), 32'd0);
      reset = 1'b0;
      tick();

      // all zeros
      launch(8'h00);
      chk("init_rst", 32'(fsm_rst1), 32'd1);
      wait_done(40, n);
      chk("latency",   32'(n + 1), 32'd10);
      chk("lit_ylog00",  32'(bus1.y_log), 32'h0000AAAA);
      chk("lit_match00", 32'(bus1.match_cnt), 32'd0);
      chk("lit_last00",  32'(bus1.last_y), 32'd2);
      chk("lit_code10",  32'(bus2.match_cnt), 32'd8);
      tick();

      // all ones, start held high through the run
      din = 8'hFF; start = 1'b1; dones = 0;
      for (int i = 0; i < 12 && dones == 0; i++) begin
         tick();
         if (bus1.done) dones++;
      end
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bus1.done) dones++;
      end
      chk("one_done",    32'(dones), 32'd1);
      chk("lit_ylogFF",  32'(bus1.y_log), 32'h0000FFFF);
      chk("lit_matchFF", 32'(bus1.match_cnt), 32'd8);
      chk("lit_lastFF",  32'(bus1.last_y), 32'd3);

      // 0x06 then immediate re-start in the cycle after done
      launch(8'h06);
      wait_done(40, n);
      chk("lit_ylog06",  32'(bus1.y_log), 32'h0000AADA);
      chk("lit_match06", 32'(bus1.match_cnt), 32'd1);
      chk("lit_last06",  32'(bus1.last_y), 32'd2);
      tick();
      launch(8'h00);
      chk("restart_rst",  32'(fsm_rst1), 32'd1);
      chk("restart_clr",  32'(bus1.y_log), 32'd0);
      chk("restart_busy", 32'(bus1.busy), 32'd1);
      wait_done(40, n);
      tick();

      // abort in step 3
      launch(8'hFF);
      for (int i = 0; i < 4; i++) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy",  32'(bus1.busy), 32'd0);
      chk("abort_match", 32'(bus1.match_cnt), 32'd4);
      chk("abort_ylog",  32'(bus1.y_log), 32'h000000FF);
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus1.done) dones++;
      end
      chk("abort_nodone", 32'(dones), 32'd0);

      // reset in step 3
      launch(8'hFF);
      for (int i = 0; i < 4; i++) tick();
      reset = 1'b1;
      tick();
      chk("rst_mid_rst",   32'(fsm_rst1), 32'd1);
      chk("rst_mid_busy",  32'(bus1.busy), 32'd0);
      chk("rst_mid_match", 32'(bus1.match_cnt), 32'd0);
      chk("rst_mid_ylog",  32'(bus1.y_log), 32'd0);
      reset = 1'b0;
      tick();

      // start pulses during INIT, RUN and DONE are ignored
      launch(8'h06);
      start = 1'b1;
      wait_done(40, n);
      tick();
      start = 1'b0;
      chk("done_start_ign", 32'(bus1.busy), 32'd0);
      tick();
      chk("still_idle", 32'(bus1.busy), 32'd0);

      // abort in IDLE has no effect; start wins over abort in IDLE
      abort = 1'b1;
      tick();
      tick();
      chk("idle_abort_hold", 32'(bus1.y_log), 32'h0000AADA);
      din = 8'hFF; start = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      chk("start_wins", 32'(bus1.busy), 32'd1);
      wait_done(40, n);
      chk("final_match", 32'(bus1.match_cnt), 32'd8);
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fsm_stream_sched.md
Name: fsm_stream_sched

Overview:
- Sequencer for the 2-bit-state Mealy detector FSM (serial input x, 2-bit output y, 2-bit state).
- Accepts a parallel word on a start/busy/done handshake, resets the detector, then feeds the word to it serially, LSB first, one bit per clock.
- Logs every 2-bit y response and counts responses equal to a programmable code.
- Sits between a host register interface and one detector instance; all three run on the same clock.

Parameters:
- WIDTH, 8, number of bits per word fed serially (range 1 to 32).
- CODE, 2'b11, y value counted by match_cnt.

Ports:
- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- abort  in  1  synchronous abort of an in-progress run
- din  in  WIDTH  word to stream; captured when start is accepted
- busy  out  1  high in INIT and RUN
- done  out  1  one-cycle pulse on normal completion
- fsm_x  out  1  serial bit to the detector's x input
- fsm_rst  out  1  to the detector's reset input
- fsm_y  in  2  detector's y output; Mealy, combinational from fsm_x
- y_log  out  2*WIDTH  y of step k at bits [2k+1:2k]
- match_cnt  out  $clog2(WIDTH+1)  number of steps where fsm_y==CODE
- last_y  out  2  y of the most recent RUN step

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, fsm_x=0, y_log=0, match_cnt=0, last_y=0, bit index=0, shift register=0.
- fsm_rst = reset OR (state==INIT), combinational; the detector is therefore also held in reset while this block is in reset.
- States and transitions (IDLE, INIT, RUN, DONE):
  - IDLE -> INIT when start=1. On that edge: load din into the shift register, clear y_log, match_cnt, last_y and the bit index.
  - INIT lasts exactly 1 cycle, with fsm_rst=1, so the detector state is 00 at RUN entry. INIT -> RUN.
  - RUN lasts exactly WIDTH cycles. In step k: fsm_x = shreg[0] = din[k].
    - On each edge: y_log[2k+1:2k] <= fsm_y; last_y <= fsm_y; match_cnt increments if fsm_y==CODE; shreg shifts right by 1, zero fill; k increments.
    - After step WIDTH-1: RUN -> DONE.
  - DONE lasts 1 cycle with done=1, busy=0. DONE -> IDLE.
- Latency: start sampled at edge E. INIT runs in the cycle after E. done=1 in cycle E+WIDTH+2.
- fsm_x=0 in every state except RUN.
- Results (y_log, match_cnt, last_y) hold from DONE until the next accepted start.
- start while busy or in DONE: ignored, with no queueing.
- abort=1 in INIT or RUN: go to IDLE on the next edge.
  - No done pulse.
  - Partial results hold, including any step sampled on that edge.
  - abort is ignored in IDLE and DONE.
- start and abort both high in IDLE: start wins, since abort is ignored in IDLE.
- reset at any time, including mid-RUN, overrides start and abort. All outputs return to their reset values on that edge.
- match_cnt saturates at WIDTH by construction; it never wraps.
- WIDTH=1: RUN lasts one cycle, and the sequence is still INIT, RUN, DONE.

Test Plan:
- WIDTH=8, reset 2 cycles, then start with din=8'h00 -> y every step 2'b10; done in cycle E+10; y_log=16'hAAAA, match_cnt=0, last_y=2'b10.
- din=8'hFF -> detector stays in state 00 with y=2'b11 every step; y_log=16'hFFFF, match_cnt=8, last_y=2'b11.
- din=8'h06, bits LSB first 0,1,1,0,0,0,0,0 -> y sequence 10,10,01,11,10,10,10,10; y_log=16'hAADA, match_cnt=1, last_y=2'b10.
- Handshake:
  - start held high through a run -> exactly one run and one done pulse.
  - Re-start in the cycle after done -> second run begins; INIT fsm_rst pulse seen; results cleared at that edge.
- Mid-operation control: run din=8'hFF.
  - abort in RUN step 3 -> back to IDLE; no done; match_cnt=4; y_log=16'h00FF.
  - Repeat with reset in step 3 -> all outputs 0; fsm_rst=1 during reset.
- Ignored inputs and CODE override:
  - start pulses during INIT, RUN and DONE -> ignored.
  - abort in IDLE -> no effect.
  - CODE=2'b10 with din=8'h00 -> match_cnt=8.
